// File: rtl/ram_pkg.sv
// Shared types and helpers for the pipelined data RAM.
package ram_pkg;

  localparam int unsigned RD_LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    RESET,
    CLEAR,
    RUN
  } state_e;

  // Index width for a given word count; never narrower than one bit.
  function automatic int unsigned addr_bits(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read response pipeline: RD_LATENCY stages of {valid, err, data}; stage 0 registers the array read.
module ram_rd_pipe #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Latency   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  input  logic                 in_err_i,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  output logic                 out_err_o,
  output logic [DataWidth-1:0] out_data_o
);

  logic [Latency-1:0]   valid_d, valid_q;
  logic [Latency-1:0]   err_d, err_q;
  logic [DataWidth-1:0] data_d [Latency];
  logic [DataWidth-1:0] data_q [Latency];

  // Data only advances alongside a valid beat so the output holds between responses.
  always_comb begin
    valid_d    = valid_q;
    err_d      = err_q;
    data_d     = data_q;
    valid_d[0] = in_valid_i;
    err_d[0]   = in_err_i;
    data_d[0]  = in_valid_i ? in_data_i : data_q[0];
    for (int k = 1; k < int'(Latency); k++) begin
      valid_d[k] = valid_q[k-1];
      err_d[k]   = err_q[k-1];
      data_d[k]  = valid_q[k-1] ? data_q[k-1] : data_q[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int k = 0; k < int'(Latency); k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q[Latency-1];
  assign out_err_o   = valid_q[Latency-1] & err_q[Latency-1];
  assign out_data_o  = data_q[Latency-1];

endmodule

// File: rtl/ram_pipelined.sv
// Single-port data RAM with valid/ready requests, byte enables and a configurable read pipeline.
// Optional post-reset zero-fill sequencer enabled by defining RAM_PIPELINED_CLEAR_EN.
module ram_pipelined
  import ram_pkg::*;
#(
  parameter int unsigned CPU_BIT_WIDTH = 32,
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned RD_LATENCY    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [CPU_BIT_WIDTH-1:0]   req_addr,
  input  logic [CPU_BIT_WIDTH/8-1:0] req_be,
  input  logic [CPU_BIT_WIDTH-1:0]   req_wdata,
  output logic                       rsp_valid,
  output logic [CPU_BIT_WIDTH-1:0]   rsp_rdata,
  output logic                       rsp_err,
  output logic                       wr_err
);

  localparam int unsigned NumBytes = CPU_BIT_WIDTH / 8;
  localparam int unsigned AddrBits = addr_bits(DEPTH);
  // Wide enough to hold both the full address and DEPTH itself.
  localparam int unsigned CmpW     = (CPU_BIT_WIDTH > 17) ? CPU_BIT_WIDTH + 1 : 18;

  if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("ram_pipelined: RD_LATENCY must be 1..%0d", RD_LATENCY_MAX);
  end
  if (CPU_BIT_WIDTH == 0 || (CPU_BIT_WIDTH % 8) != 0) begin : g_bad_width
    $error("ram_pipelined: CPU_BIT_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 2 || DEPTH > 65536 || AddrBits > CPU_BIT_WIDTH) begin : g_bad_depth
    $error("ram_pipelined: DEPTH must be 2..65536 and addressable by CPU_BIT_WIDTH bits");
  end

  state_e state_q;
  logic   req_ready_q;
`ifdef RAM_PIPELINED_CLEAR_EN
  logic [AddrBits-1:0] clr_addr_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET;
      req_ready_q <= 1'b0;
`ifdef RAM_PIPELINED_CLEAR_EN
      clr_addr_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        RESET: begin
`ifdef RAM_PIPELINED_CLEAR_EN
          state_q    <= CLEAR;
          clr_addr_q <= '0;
`else
          state_q     <= RUN;
          req_ready_q <= 1'b1;
`endif
        end
`ifdef RAM_PIPELINED_CLEAR_EN
        CLEAR: begin
          if (clr_addr_q == AddrBits'(DEPTH - 1)) begin
            state_q     <= RUN;
            req_ready_q <= 1'b1;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
`endif
        RUN: begin
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= RESET;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;

  logic                accept, rd_acc, wr_acc, in_range;
  logic [AddrBits-1:0] req_idx;

  assign accept   = req_valid & req_ready_q;
  assign rd_acc   = accept & ~req_we;
  assign wr_acc   = accept & req_we;
  assign in_range = CmpW'(req_addr) < CmpW'(DEPTH);
  assign req_idx  = req_addr[AddrBits-1:0];

  logic                     mem_we;
  logic [AddrBits-1:0]      mem_idx;
  logic [NumBytes-1:0]      mem_be;
  logic [CPU_BIT_WIDTH-1:0] mem_wdata;

  // The clear sequencer owns the write port while it runs; requests are blocked then.
  always_comb begin
    mem_we    = wr_acc & in_range;
    mem_idx   = req_idx;
    mem_be    = req_be;
    mem_wdata = req_wdata;
`ifdef RAM_PIPELINED_CLEAR_EN
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clr_addr_q;
      mem_be    = '1;
      mem_wdata = '0;
    end
`endif
  end

  logic [CPU_BIT_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(NumBytes); b++) begin
        if (mem_be[b]) begin
          mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  logic [CPU_BIT_WIDTH-1:0] rd_data;
  assign rd_data = in_range ? mem[req_idx] : '0;

  logic wr_err_d, wr_err_q;
  assign wr_err_d = wr_acc & ~in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;

  ram_rd_pipe #(
    .DataWidth (CPU_BIT_WIDTH),
    .Latency   (RD_LATENCY)
  ) u_rd_pipe (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (rd_acc),
    .in_err_i    (~in_range),
    .in_data_i   (rd_data),
    .out_valid_o (rsp_valid),
    .out_err_o   (rsp_err),
    .out_data_o  (rsp_rdata)
  );

endmodule
